// File: rtl/eq_serial_cmp_amisha.sv
// eq_serial_cmp_amisha: bit-serial MSB-first word comparator reporting eq/gt/lt and mismatch count.
module eq_serial_cmp_amisha #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clk_amisha,
    input  logic          reset_amisha,
    input  logic          start_amisha,
    input  logic          bit_valid_amisha,
    input  logic          i0_amisha,
    input  logic          i1_amisha,
    output logic          busy_amisha,
    output logic          done_amisha,
    output logic          eq_amisha,
    output logic          gt_amisha,
    output logic          lt_amisha,
    output logic [CW-1:0] mismatch_cnt_amisha
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] idx, acc_cnt;
    logic acc_eq, acc_gt, acc_lt, take, last, diff;
    assign take = (state == RUN) && bit_valid_amisha;
    assign last = idx == CW'(WIDTH - 1);
    assign diff = i0_amisha ^ i1_amisha;
    assign busy_amisha = state == RUN;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && start_amisha) ? RUN :
                   (take && last) ? DONE :
                   (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            idx <= '0;
            acc_cnt <= '0;
            acc_eq <= 1'b0;
            acc_gt <= 1'b0;
            acc_lt <= 1'b0;
        end else if (state == IDLE && start_amisha) begin
            idx <= '0;
            acc_cnt <= '0;
            acc_eq <= 1'b1;
            acc_gt <= 1'b0;
            acc_lt <= 1'b0;
        end else if (take) begin
            idx <= idx + 1'b1;
            acc_cnt <= acc_cnt + CW'(diff);
            // Only the first differing bit (MSB side) sets the order.
            if (acc_eq && diff) begin
                acc_eq <= 1'b0;
                acc_gt <= i0_amisha;
                acc_lt <= i1_amisha;
            end
        end
    end
    // Results load as DONE retires, so done and the new values appear together.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            done_amisha <= 1'b0;
            eq_amisha <= 1'b0;
            gt_amisha <= 1'b0;
            lt_amisha <= 1'b0;
            mismatch_cnt_amisha <= '0;
        end else begin
            done_amisha <= state == DONE;
            if (state == DONE) begin
                eq_amisha <= acc_eq;
                gt_amisha <= acc_gt;
                lt_amisha <= acc_lt;
                mismatch_cnt_amisha <= acc_cnt;
            end
        end
    end
endmodule

// File: tb/tb_eq_serial_cmp_amisha.sv
// tb_eq_serial_cmp_amisha: directed checks of the serial comparator.
module tb_eq_serial_cmp_amisha;
    logic clk = 0, reset = 1, start = 0, bit_valid = 0, i0 = 0, i1 = 0;
    logic busy, done, eq, gt, lt;
    logic [3:0] cnt;
    logic [6:0] res;
    int n_chk = 0, n_fail = 0, cyc;
    assign res = {eq, gt, lt, cnt};
    always #5 clk = ~clk;
    eq_serial_cmp_amisha #(.WIDTH(8)) dut (
        .clk_amisha(clk), .reset_amisha(reset), .start_amisha(start),
        .bit_valid_amisha(bit_valid), .i0_amisha(i0), .i1_amisha(i1),
        .busy_amisha(busy), .done_amisha(done), .eq_amisha(eq), .gt_amisha(gt),
        .lt_amisha(lt), .mismatch_cnt_amisha(cnt)
    );
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit gap,
                        input bit mid_start, input bit chk_hold, input logic [6:0] hold,
                        output int c);
        @(negedge clk);
        start = 1; bit_valid = 1; i0 = 1; i1 = 0;
        @(negedge clk);
        start = 0; bit_valid = 0; c = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_valid = 1; i0 = a[i]; i1 = b[i]; start = mid_start && i == 4;
            if (i == 4) begin
                chk("busy_in_run", busy, 1);
                chk("done_in_run", done, 0);
                if (chk_hold) chk("hold_in_run", res, hold);
            end
            @(negedge clk);
            c++;
            start = 0;
            if (gap) begin
                bit_valid = 0;
                @(negedge clk);
                c++;
            end
        end
        bit_valid = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
    endtask
    task automatic after_done();
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("reset_res", res, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 0;
        send(8'hA5, 8'hA5, 0, 0, 0, 7'h0, cyc);
        chk("t1_res", res, 7'b100_0000);
        chk("t1_lat", cyc, 9);
        after_done();
        send(8'h80, 8'h7F, 0, 0, 0, 7'h0, cyc);
        chk("t2_res", res, 7'b010_1000);
        after_done();
        send(8'h10, 8'h11, 1, 0, 0, 7'h0, cyc);
        chk("t3_res", res, 7'b001_0001);
        chk("t3_lat", cyc, 16);
        after_done();
        send(8'h3C, 8'h35, 0, 1, 0, 7'h0, cyc);
        chk("t4_res", res, 7'b010_0010);
        chk("t4_lat", cyc, 9);
        after_done();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1; i0 = 1; i1 = i[0];
            @(negedge clk);
        end
        #2 reset = 1;
        #1;
        chk("t5_reset_res", res, 0);
        chk("t5_reset_busy", busy, 0);
        chk("t5_reset_done", done, 0);
        bit_valid = 0;
        @(negedge clk);
        reset = 0;
        send(8'hFF, 8'hFF, 0, 0, 0, 7'h0, cyc);
        chk("t5_res", res, 7'b100_0000);
        after_done();
        send(8'h00, 8'h01, 0, 0, 0, 7'h0, cyc);
        chk("t6a_res", res, 7'b001_0001);
        send(8'h80, 8'h00, 0, 0, 1, 7'b001_0001, cyc);
        chk("t6b_res", res, 7'b010_0001);
        after_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
